// File: rtl/hny_msg_sequencer_pkg.sv
// Shared definitions for the HAPPY NEW YEAR 2026 message sequencer.
// Contents: FSM state enum, default message length, char index width,
// dwell counter width and the speed-to-dwell lookup.
package hny_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHOW,
    GAP,
    DONE
  } state_t;

  localparam int unsigned MSG_LEN_DEFAULT = 19;
  localparam int unsigned CHAR_IDX_W      = 5;
  localparam int unsigned DWELL_W         = 4;

  // Dwell ticks per character, indexed by speed: 0 -> 8 ... 3 -> 1
  localparam logic [DWELL_W-1:0] DWELL_TABLE [4] = '{4'd8, 4'd4, 4'd2, 4'd1};

  function automatic logic [DWELL_W-1:0] dwell_of(input logic [1:0] speed);
    return DWELL_TABLE[speed];
  endfunction

endpackage

// File: rtl/hny_msg_sequencer_if.sv
// Character hand-off bus between the sequencer and the glyph decoder.
//   char_idx   : message index offered to the decoder
//   char_valid : index is being offered
//   char_ready : decoder accepts the index
// master = sequencer side, slave = decoder side.
interface hny_msg_sequencer_if;
  import hny_pkg::*;

  logic [CHAR_IDX_W-1:0] char_idx;
  logic                  char_valid;
  logic                  char_ready;

  modport master (output char_idx, output char_valid, input char_ready);
  modport slave  (input char_idx, input char_valid, output char_ready);

endinterface

// File: rtl/hny_tick_gen.sv
// Dwell prescaler: counts enabled cycles 0..PRESCALE_MAX-1 and flags a tick
// on the wrapping cycle.
//   clk, rst_n : clock, async active-low reset
//   en         : count enable (ena & ~pause & timed state)
//   clr        : synchronous clear to 0
//   tick_c     : combinational tick, high on the enabled cycle at PRESCALE_MAX-1
module hny_tick_gen #(
  parameter int unsigned PRESCALE_MAX = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned PW = (PRESCALE_MAX > 1) ? $clog2(PRESCALE_MAX) : 1;
  localparam logic [PW-1:0] CNT_MAX = PW'(PRESCALE_MAX - 1);

  logic [PW-1:0] cnt;

  assign tick_c = en & (cnt == CNT_MAX);

  // Prescaler counter with clear priority over enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + PW'(1);
    end
  end

endmodule

// File: rtl/hny_msg_sequencer.sv
// Playback controller for the "HAPPY NEW YEAR 2026" message. Steps a char
// index through the message, offers each index over a valid/ready bus and
// holds it for a speed-selected number of prescaler ticks.
//   clk, rst_n : clock, async active-low reset
//   ena        : global enable, all state frozen when low
//   start      : begin playback (IDLE only)
//   pause      : freezes dwell timing while high
//   speed      : dwell select, 0..3 -> 8/4/2/1 ticks
//   bus        : char_idx / char_valid / char_ready hand-off (master)
//   blank      : display blank request (GAP state)
//   busy       : high outside IDLE
//   done       : one-cycle pulse at message end
// Optional feature macro: HNY_BLANK_GAP_EN inserts a one-tick blanked GAP
// state after every character; when undefined, blank is tied low.
module hny_msg_sequencer
  import hny_pkg::*;
#(
  parameter int unsigned MSG_LEN      = MSG_LEN_DEFAULT,
  parameter int unsigned PRESCALE_MAX = 1_000_000,
  parameter int unsigned LOOP         = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic                       start,
  input  logic                       pause,
  input  logic [1:0]                 speed,
  hny_msg_sequencer_if.master        bus,
  output logic                       blank,
  output logic                       busy,
  output logic                       done
);

  localparam logic [CHAR_IDX_W-1:0] LAST_IDX = CHAR_IDX_W'(MSG_LEN - 1);

  state_t                state;
  logic [DWELL_W-1:0]    dwell;
  logic [CHAR_IDX_W-1:0] idx;
  logic                  valid;

  logic timed_c;
  logic tick_c;
  logic show_end_c;
  logic advance_c;

  assign bus.char_idx   = idx;
  assign bus.char_valid = valid;

  // Prescaler runs only while a character (or gap) is being timed
  assign timed_c = (state == SHOW) || (state == GAP);

  hny_tick_gen #(
    .PRESCALE_MAX (PRESCALE_MAX)
  ) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (ena & ~pause & timed_c),
    .clr    (ena & ~timed_c),
    .tick_c (tick_c)
  );

  assign show_end_c = (state == SHOW) && tick_c && (dwell == DWELL_W'(1));

`ifdef HNY_BLANK_GAP_EN
  logic blank_q;
  assign blank     = blank_q;
  assign advance_c = (state == GAP) && tick_c;
`else
  assign blank     = 1'b0;
  assign advance_c = show_end_c;
`endif

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      dwell   <= '0;
      idx     <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef HNY_BLANK_GAP_EN
      blank_q <= 1'b0;
`endif
    end else if (ena) begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            idx   <= '0;
            valid <= 1'b1;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          if (bus.char_ready) begin
            state <= SHOW;
            valid <= 1'b0;
            dwell <= dwell_of(speed);
          end
        end
        SHOW: begin
          if (tick_c && (dwell != DWELL_W'(1))) begin
            dwell <= dwell - DWELL_W'(1);
          end
`ifdef HNY_BLANK_GAP_EN
          if (show_end_c) begin
            state   <= GAP;
            blank_q <= 1'b1;
          end
`endif
        end
        GAP: begin
`ifdef HNY_BLANK_GAP_EN
          if (advance_c) begin
            blank_q <= 1'b0;
          end
`else
          state <= IDLE;
`endif
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      // End of a character: next index, wrap, or finish
      if (advance_c) begin
        if (idx != LAST_IDX) begin
          idx   <= idx + CHAR_IDX_W'(1);
          state <= LOAD;
          valid <= 1'b1;
        end else if (LOOP != 0) begin
          idx   <= '0;
          state <= LOAD;
          valid <= 1'b1;
          done  <= 1'b1;
        end else begin
          state <= DONE;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hny_msg_sequencer.sv
// Self-checking bench for hny_msg_sequencer (PRESCALE_MAX=4, MSG_LEN=19).
// Two instances share stimulus: one with LOOP=0, one with LOOP=1.
module tb_hny_msg_sequencer;

  localparam int PRE = 4;
  localparam int LEN = 19;
`ifdef HNY_BLANK_GAP_EN
  localparam bit GAP_EN  = 1'b1;
  localparam int GAP_CYC = PRE;
`else
  localparam bit GAP_EN  = 1'b0;
  localparam int GAP_CYC = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [1:0] speed = 2'd3;
  logic       ready = 1'b0;

  logic blank_s, busy_s, done_s;
  logic blank_l, busy_l, done_l;

  int n_err = 0;
  int n_checks = 0;
  bit chk_on = 1'b0;

  hny_msg_sequencer_if bus_s ();
  hny_msg_sequencer_if bus_l ();
  assign bus_s.char_ready = ready;
  assign bus_l.char_ready = ready;

  hny_msg_sequencer #(.MSG_LEN(LEN), .PRESCALE_MAX(PRE), .LOOP(0)) dut_stop (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .pause(pause),
    .speed(speed), .bus(bus_s), .blank(blank_s), .busy(busy_s), .done(done_s)
  );

  hny_msg_sequencer #(.MSG_LEN(LEN), .PRESCALE_MAX(PRE), .LOOP(1)) dut_loop (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .pause(pause),
    .speed(speed), .bus(bus_l), .blank(blank_l), .busy(busy_l), .done(done_l)
  );

  always #5 clk = ~clk;

  task automatic ck(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 offering, 2 showing, 3 gap, 4 ending.
  // A character is timed as a budget of unpaused enabled cycles.
  typedef struct {
    int mode;
    int rem;
    int idx;
    bit valid;
    bit busy;
    bit done;
    bit blank;
  } mdl_t;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.mode = 0; m.rem = 0; m.idx = 0;
    m.valid = 0; m.busy = 0; m.done = 0; m.blank = 0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, bit loop_en, bit e, bit st, bit pa,
                                    logic [1:0] sp, bit rd);
    mdl_t n = m;
    if (!e) return n;
    n.done = 0;
    case (m.mode)
      0: if (st) begin n.mode = 1; n.idx = 0; n.valid = 1; n.busy = 1; end
      1: if (rd) begin n.mode = 2; n.valid = 0; n.rem = (8 >> sp) * PRE; end
      2, 3: if (!pa) begin
        n.rem = m.rem - 1;
        if (n.rem == 0) begin
          if (GAP_EN && m.mode == 2) begin
            n.mode = 3; n.rem = PRE; n.blank = 1;
          end else begin
            n.blank = 0;
            if (m.idx < LEN - 1) begin
              n.idx = m.idx + 1; n.mode = 1; n.valid = 1;
            end else if (loop_en) begin
              n.idx = 0; n.mode = 1; n.valid = 1; n.done = 1;
            end else begin
              n.mode = 4; n.done = 1;
            end
          end
        end
      end
      4: begin n.mode = 0; n.busy = 0; end
      default: n.mode = 0;
    endcase
    return n;
  endfunction

  mdl_t m_stop;
  mdl_t m_loop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_stop <= mdl_reset();
      m_loop <= mdl_reset();
    end else begin
      m_stop <= mdl_step(m_stop, 1'b0, ena, start, pause, speed, ready);
      m_loop <= mdl_step(m_loop, 1'b1, ena, start, pause, speed, ready);
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_on) begin
      ck("stop.valid", 32'(bus_s.char_valid), 32'(m_stop.valid));
      ck("stop.idx",   32'(bus_s.char_idx),   32'(m_stop.idx));
      ck("stop.busy",  32'(busy_s),           32'(m_stop.busy));
      ck("stop.done",  32'(done_s),           32'(m_stop.done));
      ck("stop.blank", 32'(blank_s),          32'(m_stop.blank));
      ck("loop.valid", 32'(bus_l.char_valid), 32'(m_loop.valid));
      ck("loop.idx",   32'(bus_l.char_idx),   32'(m_loop.idx));
      ck("loop.busy",  32'(busy_l),           32'(m_loop.busy));
      ck("loop.done",  32'(done_l),           32'(m_loop.done));
      ck("loop.blank", 32'(blank_l),          32'(m_loop.blank));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic       start;
    logic       ready;
    logic       pause;
    logic [1:0] speed;
    logic       e_valid;
    logic [4:0] e_idx;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t tbl [16];
  int cnt;
  int ndone;
  int nidle;

  task automatic set_vec(input int i, input logic st, input logic rd, input logic pa,
                         input logic [1:0] sp, input logic v, input logic [4:0] ix,
                         input logic b, input logic d);
    tbl[i].start = st; tbl[i].ready = rd; tbl[i].pause = pa; tbl[i].speed = sp;
    tbl[i].e_valid = v; tbl[i].e_idx = ix; tbl[i].e_busy = b; tbl[i].e_done = d;
  endtask

  initial begin
    // start, ready, pause, speed -> valid, idx, busy, done
    set_vec(0,  0, 0, 0, 3,  0, 0, 0, 0);
    set_vec(1,  1, 0, 0, 3,  1, 0, 1, 0);
    set_vec(2,  0, 0, 0, 3,  1, 0, 1, 0);
    set_vec(3,  0, 1, 0, 3,  0, 0, 1, 0);
    set_vec(4,  0, 1, 0, 3,  0, 0, 1, 0);
    set_vec(5,  0, 1, 0, 3,  0, 0, 1, 0);
    set_vec(6,  0, 1, 0, 3,  0, 0, 1, 0);
    set_vec(7,  0, 0, 0, 3,  1, 1, 1, 0);
    set_vec(8,  0, 0, 0, 3,  1, 1, 1, 0);
    set_vec(9,  0, 1, 0, 3,  0, 1, 1, 0);
    set_vec(10, 0, 1, 1, 3,  0, 1, 1, 0);
    set_vec(11, 1, 1, 1, 3,  0, 1, 1, 0);
    set_vec(12, 0, 1, 0, 3,  0, 1, 1, 0);
    set_vec(13, 0, 1, 0, 3,  0, 1, 1, 0);
    set_vec(14, 0, 1, 0, 3,  0, 1, 1, 0);
    set_vec(15, 0, 1, 0, 3,  1, 2, 1, 0);

    // Reset state
    tick();
    ck("rst.valid", 32'(bus_s.char_valid), 32'(0));
    ck("rst.idx",   32'(bus_s.char_idx),   32'(0));
    ck("rst.busy",  32'(busy_s),           32'(0));
    ck("rst.done",  32'(done_s),           32'(0));
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk_on = 1'b1;

    // Table-driven opening sequence
    for (int i = 0; i < 16; i++) begin
      start = tbl[i].start; ready = tbl[i].ready;
      pause = tbl[i].pause; speed = tbl[i].speed;
      tick();
      ck($sformatf("vec%0d.valid", i), 32'(bus_s.char_valid), 32'(tbl[i].e_valid));
      ck($sformatf("vec%0d.idx", i),   32'(bus_s.char_idx),   32'(tbl[i].e_idx));
      ck($sformatf("vec%0d.busy", i),  32'(busy_s),           32'(tbl[i].e_busy));
      ck($sformatf("vec%0d.done", i),  32'(done_s),           32'(tbl[i].e_done));
    end
    start = 0; pause = 0; ready = 1; speed = 3;

    // Reset mid-SHOW at index 7
    cnt = 0;
    while (!(bus_s.char_idx == 5'd7 && !bus_s.char_valid) && cnt < 200) begin
      tick(); cnt++;
    end
    ck("reach_idx7", 32'(bus_s.char_idx), 32'(7));
    rst_n = 1'b0;
    #1;
    ck("async_rst.valid", 32'(bus_s.char_valid), 32'(0));
    ck("async_rst.idx",   32'(bus_s.char_idx),   32'(0));
    ck("async_rst.busy",  32'(busy_s),           32'(0));
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    ck("post_rst.busy",  32'(busy_s),           32'(0));
    ck("post_rst.valid", 32'(bus_s.char_valid), 32'(0));
    start = 1;
    tick();
    start = 0;
    ck("restart.valid", 32'(bus_s.char_valid), 32'(1));
    ck("restart.idx",   32'(bus_s.char_idx),   32'(0));

    // Full run at speed 3: done about 96 cycles after start
    cnt = 1;
    while (!done_s && cnt < 400) begin
      tick(); cnt++;
    end
    ck("done_latency", 32'(cnt), 32'(LEN * (5 + GAP_CYC) + 1));
    ck("done.idx",  32'(bus_s.char_idx), 32'(LEN - 1));
    ck("done.busy", 32'(busy_s),         32'(1));
    tick();
    ck("after_done.done", 32'(done_s),         32'(0));
    ck("after_done.busy", 32'(busy_s),         32'(0));
    ck("after_done.idx",  32'(bus_s.char_idx), 32'(LEN - 1));

    // Backpressure at index 3
    start = 1;
    tick();
    start = 0;
    cnt = 0;
    while (!(bus_s.char_idx == 5'd3 && bus_s.char_valid) && cnt < 100) begin
      tick(); cnt++;
    end
    ck("reach_idx3", 32'(bus_s.char_idx), 32'(3));
    ready = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      ck("bp.valid", 32'(bus_s.char_valid), 32'(1));
      ck("bp.idx",   32'(bus_s.char_idx),   32'(3));
    end
    ready = 1;
    tick();
    ck("bp_release.valid", 32'(bus_s.char_valid), 32'(0));
    cnt = 0;
    while (!bus_s.char_valid && cnt < 100) begin
      tick(); cnt++;
    end
    ck("show_len_speed3", 32'(cnt), 32'(PRE + GAP_CYC));
    ck("next_idx", 32'(bus_s.char_idx), 32'(4));

    // Pause for 20 cycles in a speed-0 SHOW
    speed = 0;
    tick();
    repeat (5) tick();
    pause = 1;
    repeat (20) tick();
    ck("pause.idx",   32'(bus_s.char_idx),   32'(4));
    ck("pause.valid", 32'(bus_s.char_valid), 32'(0));
    pause = 0;
    cnt = 0;
    while (!bus_s.char_valid && cnt < 200) begin
      tick(); cnt++;
    end
    ck("pause_show_rest", 32'(cnt), 32'(8 * PRE - 5 + GAP_CYC));

    // ena low freezes an offered index
    ena = 0; speed = 3;
    for (int i = 0; i < 5; i++) begin
      tick();
      ck("ena0.valid", 32'(bus_s.char_valid), 32'(1));
      ck("ena0.idx",   32'(bus_s.char_idx),   32'(5));
      ck("ena0.busy",  32'(busy_s),           32'(1));
    end
    ena = 1;
    tick();
    ck("ena1.valid", 32'(bus_s.char_valid), 32'(0));

    // Loop instance: wraps to 0 with a done pulse, busy stays high, start ignored
    rst_n = 0;
    tick();
    rst_n = 1;
    start = 1; ready = 1; speed = 3;
    ndone = 0; nidle = 0;
    for (int i = 0; i < 2 * LEN * (5 + GAP_CYC) + 10; i++) begin
      tick();
      if (done_l) begin
        ndone++;
        ck("wrap.idx",   32'(bus_l.char_idx),   32'(0));
        ck("wrap.valid", 32'(bus_l.char_valid), 32'(1));
      end
      if (!busy_l) nidle++;
    end
    ck("loop.done_count", 32'(ndone), 32'(2));
    ck("loop.idle_cycles", 32'(nidle), 32'(0));
    start = 0;

    // Randomized stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      ena   = ($urandom_range(0, 9) != 0);
      start = ($urandom_range(0, 7) == 0);
      pause = ($urandom_range(0, 4) == 0);
      speed = 2'($urandom_range(0, 3));
      ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    rst_n = 1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/hny_msg_sequencer.md
Name: hny_msg_sequencer

Overview:
- Playback controller for the "HAPPY NEW YEAR 2026" message in tt_um_HappyNewYear2026.
- Steps a character index through the message and hands each index to the downstream glyph decoder/display datapath over a valid/ready handshake.
- Holds each character for a programmable dwell time, with start, pause and speed control coming from ui_in.
- Sits between the top-level input pins and the glyph ROM / segment driver.

Parameters:
- MSG_LEN, 19, number of characters in the message; index range 0..MSG_LEN-1.
- PRESCALE_MAX, 1_000_000, clk cycles per dwell tick; the prescaler counts 0..PRESCALE_MAX-1.
- LOOP, 0, 1 = restart at index 0 after the last character; 0 = stop.

Ports:
- clk in 1: system clock.
- rst_n in 1: reset, asynchronous, active-low.
- ena in 1: design enable; when low, all state is frozen.
- start in 1: begins playback; sampled in IDLE only.
- pause in 1: level; freezes dwell timing while high.
- speed in 2: dwell select; 0 = 8 ticks, 1 = 4, 2 = 2, 3 = 1 tick per character.
- char_idx out 5: current message index.
- char_valid out 1: index offered to the decoder.
- char_ready in 1: decoder accepts the index.
- blank out 1: display-blank request.
- busy out 1: high in every state except IDLE.
- done out 1: one-cycle pulse at message end.

Behaviour:
- Reset values: char_idx=0, char_valid=0, blank=0, busy=0, done=0, state=IDLE, prescaler=0, dwell count=0.
- Clocking: all outputs are registered. Every transition requires ena=1; with ena=0, state and outputs hold.
- IDLE:
  - start=1 -> LOAD next cycle, with char_idx=0, char_valid=1, busy=1.
  - start is ignored in every other state.
- LOAD:
  - char_valid=1, and char_idx is stable until the handshake completes.
  - Handshake completes in the cycle where char_valid & char_ready = 1.
  - On handshake: next state SHOW, char_valid=0, prescaler=0.
  - Dwell count loads from speed, which is sampled at the handshake.
- SHOW:
  - The prescaler increments each cycle. At PRESCALE_MAX-1 it issues a tick and wraps to 0.
  - Each tick decrements the dwell count.
  - Last tick when index < MSG_LEN-1 -> LOAD with char_idx+1.
  - Last tick when index = MSG_LEN-1:
    - LOOP=0 -> DONE.
    - LOOP=1 -> LOAD with char_idx=0, plus a done pulse in that same cycle.
  - Minimum SHOW length is PRESCALE_MAX cycles (speed=3).
- Pause: while pause=1 in SHOW, the prescaler and dwell count hold. pause has no effect in LOAD or IDLE.
- DONE: done=1 for exactly 1 cycle, then IDLE with busy=0. char_idx holds MSG_LEN-1 until the next start.
- Width rules:
  - Prescaler width is clog2(PRESCALE_MAX).
  - Dwell counter is 4 bits.
  - char_idx never exceeds MSG_LEN-1.
- Simultaneous events:
  - pause rising in the same cycle as the final tick: pause wins; the tick is not counted.
- Reset mid-operation: immediate return to reset values. There is no partial handshake; char_valid drops asynchronously.

Optional Feature:
- Macro: HNY_BLANK_GAP_EN.
- Defined:
  - A GAP state is inserted between SHOW and the next LOAD (and before DONE).
  - GAP lasts exactly 1 tick (PRESCALE_MAX cycles) with blank=1. pause freezes GAP as well.
  - Per-character period becomes (dwell+1) ticks plus the handshake cycles.
- Undefined:
  - No GAP state; blank is tied to 0.

Decomposition:
- Shared package hny_pkg holds:
  - the state enum: IDLE, LOAD, SHOW, GAP, DONE.
  - MSG_LEN_DEFAULT=19.
  - the speed-to-dwell constant array {8,4,2,1}.
  - the char_idx width constant (5).
- One sub-module, hny_tick_gen: the prescaler with enable (ena & ~pause & in-timed-state), synchronous clear and tick output. The sequencer FSM stays in the parent.

Test Plan:
All scenarios use PRESCALE_MAX=4, MSG_LEN=19, macro undefined unless stated.
1. Reset: assert rst_n=0 mid-SHOW at char_idx=7 -> all outputs 0 in the same cycle; state IDLE after release; start needed to resume from idx 0.
2. Full run: speed=3, char_ready=1, start pulse -> char_valid=1/idx=0 one cycle later; each character takes 1 LOAD + 4 SHOW = 5 cycles; idx 18 reached; done=1 for 1 cycle about 96 cycles after start; busy=0 next cycle.
3. Backpressure: char_ready=0 for 10 cycles at idx=3 -> char_valid stays 1, idx stays 3, no prescaler advance; SHOW begins the cycle after char_ready=1.
4. Pause: pause=1 for 20 cycles mid-SHOW at speed=0 -> SHOW lasts 32+20 cycles; idx unchanged during pause; ena=0 for 5 cycles -> all outputs frozen.
5. Loop: LOOP=1 -> after idx 18, idx=0 in LOAD; done pulses once per wrap; busy never drops; a start during playback is ignored.
6. Gap: HNY_BLANK_GAP_EN defined, speed=3 -> blank=1 for exactly 4 cycles between characters; per-character period is 9 cycles; blank=0 during LOAD and SHOW.
